// File: rtl/spi_midi_decoder.sv
// spi_midi_decoder: turns the byte stream from an upstream SPI receiver into
// note gate/pitch/velocity and control-change registers for one MIDI channel,
// and keeps a saturating count of protocol errors.
module spi_midi_decoder #(
    parameter logic [3:0]  CHANNEL        = 4'd0,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_gate,
    output logic [6:0] o_note,
    output logic [6:0] o_velocity,
    output logic       o_note_strobe,
    output logic [6:0] o_cc_num,
    output logic [6:0] o_cc_val,
    output logic       o_cc_strobe,
    output logic [7:0] o_err_count
);

    typedef enum logic [1:0] { IDLE, DATA1, DATA2 } state_e;
    // CMD_NONE also marks a message for another channel: its data bytes are
    // parsed and swallowed silently, but nothing executes on completion.
    typedef enum logic [1:0] { CMD_NONE, CMD_NOTE_ON, CMD_NOTE_OFF, CMD_CC } cmd_e;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d, status_cmd;
    logic [6:0]  d1_q, d1_d;
    logic [15:0] timer_q, timer_d;
    logic        gate_q, gate_d;
    logic [6:0]  note_q, note_d;
    logic [6:0]  vel_q, vel_d;
    logic [6:0]  cc_num_q, cc_num_d;
    logic [6:0]  cc_val_q, cc_val_d;
    logic        note_strobe_q, note_strobe_d;
    logic        cc_strobe_q, cc_strobe_d;
    logic [7:0]  err_q, err_d;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;

    logic       is_status, is_data, known_cmd, timeout, note_off;
    logic [6:0] d2;

    assign is_status = i_data_valid & i_data[7];
    assign is_data   = i_data_valid & ~i_data[7];
    assign d2        = i_data[6:0];
    // A byte arriving on the expiry edge wins over the timeout.
    assign timeout   = (state_q != IDLE) && !i_data_valid && (timer_q == TIMEOUT_LAST);
    assign note_off  = (cmd_q == CMD_NOTE_OFF) || ((cmd_q == CMD_NOTE_ON) && (d2 == 7'd0));

    // Classify a status byte: is it a known command type, and which command it latches here.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        known_cmd  = 1'b1;
        status_cmd = CMD_NONE;
        case (i_data[7:4])
            4'h9:    status_cmd = CMD_NOTE_ON;
            4'h8:    status_cmd = CMD_NOTE_OFF;
            4'hB:    status_cmd = CMD_CC;
            default: known_cmd  = 1'b0;
        endcase
        if (i_data[3:0] != CHANNEL) status_cmd = CMD_NONE;
    end

    // Parser state register.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: status bytes restart from any state, data bytes advance.
    always_comb begin
        state_d = state_q;
        if (is_status) begin
            state_d = known_cmd ? DATA1 : IDLE;
        end else if (is_data) begin
            case (state_q)
                DATA1:   state_d = DATA2;
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
        end
    end

    // Datapath and output next values: latching, command execution, error accounting.
    always_comb begin
        cmd_d         = cmd_q;
        d1_d          = d1_q;
        timer_d       = timer_q;
        gate_d        = gate_q;
        note_d        = note_q;
        vel_d         = vel_q;
        cc_num_d      = cc_num_q;
        cc_val_d      = cc_val_q;
        note_strobe_d = 1'b0;
        cc_strobe_d   = 1'b0;
        err_inc       = 2'd0;

        if (i_data_valid)          timer_d = 16'd0;
        else if (state_q != IDLE)  timer_d = timeout ? 16'd0 : timer_q + 16'd1;

        if (is_status) begin
            cmd_d = status_cmd;
            if (state_q != IDLE) err_inc = err_inc + 2'd1;  // partial message aborted
            if (!known_cmd)      err_inc = err_inc + 2'd1;  // unsupported status
        end else if (is_data) begin
            case (state_q)
                IDLE:  err_inc = 2'd1;                      // stray data, no running status
                DATA1: d1_d    = i_data[6:0];
                DATA2: begin
                    if (cmd_q == CMD_CC) begin
                        cc_num_d    = d1_q;
                        cc_val_d    = d2;
                        cc_strobe_d = 1'b1;
                    end else if ((cmd_q == CMD_NOTE_ON) && (d2 != 7'd0)) begin
                        note_d        = d1_q;
                        vel_d         = d2;
                        gate_d        = 1'b1;
                        note_strobe_d = 1'b1;
                    end else if (note_off && (d1_q == note_q)) begin
                        gate_d        = 1'b0;
                        note_strobe_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timeout) begin
            err_inc = 2'd1;
        end

        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q         <= CMD_NONE;
            d1_q          <= 7'd0;
            timer_q       <= 16'd0;
            gate_q        <= 1'b0;
            note_q        <= 7'd0;
            vel_q         <= 7'd0;
            cc_num_q      <= 7'd0;
            cc_val_q      <= 7'd0;
            note_strobe_q <= 1'b0;
            cc_strobe_q   <= 1'b0;
            err_q         <= 8'd0;
        end else begin
            cmd_q         <= cmd_d;
            d1_q          <= d1_d;
            timer_q       <= timer_d;
            gate_q        <= gate_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            cc_num_q      <= cc_num_d;
            cc_val_q      <= cc_val_d;
            note_strobe_q <= note_strobe_d;
            cc_strobe_q   <= cc_strobe_d;
            err_q         <= err_d;
        end
    end

    assign o_gate        = gate_q;
    assign o_note        = note_q;
    assign o_velocity    = vel_q;
    assign o_note_strobe = note_strobe_q;
    assign o_cc_num      = cc_num_q;
    assign o_cc_val      = cc_val_q;
    assign o_cc_strobe   = cc_strobe_q;
    assign o_err_count   = err_q;

endmodule
